// File: rtl/csr_machine_pkg.sv
// Shared constants and wire bundles for the machine-mode CSR unit: CSR addresses,
// interrupt cause codes, privilege encodings, status/interrupt bit positions.
package csr_machine_pkg;

  localparam logic [11:0] CSR_MSTATUS        = 12'h300;
  localparam logic [11:0] CSR_MISA           = 12'h301;
  localparam logic [11:0] CSR_MIE            = 12'h304;
  localparam logic [11:0] CSR_MTVEC          = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN     = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h323;
  localparam logic [11:0] CSR_MSCRATCH       = 12'h340;
  localparam logic [11:0] CSR_MEPC           = 12'h341;
  localparam logic [11:0] CSR_MCAUSE         = 12'h342;
  localparam logic [11:0] CSR_MTVAL          = 12'h343;
  localparam logic [11:0] CSR_MIP            = 12'h344;
  localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
  localparam logic [11:0] CSR_MHPMCNT_BASE   = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
  localparam logic [11:0] CSR_MHPMCNTH_BASE  = 12'hB83;

  localparam logic [4:0] IRQ_MSI        = 5'd3;
  localparam logic [4:0] IRQ_MTI        = 5'd7;
  localparam logic [4:0] IRQ_MEI        = 5'd11;
  localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_M = 2'b11;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIP_MSI      = 3;
  localparam int unsigned MIP_MTI      = 7;
  localparam int unsigned MIP_MEI      = 11;
  localparam int unsigned MIP_LOCAL    = 16;

  localparam logic [31:0] MISA_VALUE = 32'h4000_1104;

  localparam int unsigned CNT_CYCLE   = 0;
  localparam int unsigned CNT_INSTRET = 1;

  typedef logic [63:0] cnt64_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic        st_mie;
    logic        st_mpie;
    logic [1:0]  st_mpp;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mscratch;
    logic [31:0] mcounteren;
    logic [31:0] mcountinhibit;
  } csr_state_t;

  typedef struct packed {
    csr_state_t        st;
    logic [31:0]       mip;
    cnt64_t [1:0]      cnt;
  } csr_machine_reg;

  function automatic logic [31:0] irq_mask(input int unsigned lirq_num);
    logic [31:0] m;
    m = '0;
    m[MIP_MSI] = 1'b1;
    m[MIP_MTI] = 1'b1;
    m[MIP_MEI] = 1'b1;
    for (int unsigned i = 0; i < lirq_num; i++) m[MIP_LOCAL + i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_machine_counter64.sv
// 64-bit event counter with inhibit and independent half-word CSR writes.
module csr_counter64
  import csr_machine_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inhibit_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output cnt64_t      count_o
);

  cnt64_t cnt_q, cnt_d;

  // A write to either half suppresses the increment; the untouched half holds.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_machine.sv
// Machine-mode CSR unit: trap/mret sequencing, interrupt arbitration, counters.
// Optional HPM counters are built when CSR_HPM_EN is defined.
module csr_machine
  import csr_machine_pkg::*;
#(
  parameter int unsigned LIRQ_NUM = 4,
  parameter int unsigned HPM_NUM  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                crden,
  input  logic [11:0]         craddr,
  output logic [31:0]         crdata,
  input  logic                cwren,
  input  logic [11:0]         cwaddr,
  input  logic [31:0]         cwdata,
  input  logic                valid,
  input  logic                exception,
  input  logic [4:0]          ecause,
  input  logic [31:0]         epc,
  input  logic [31:0]         etval,
  input  logic                mret_in,
  input  logic                meip,
  input  logic                msip,
  input  logic                mtip,
  input  logic [LIRQ_NUM-1:0] lirq,
  input  logic [HPM_NUM-1:0]  hpm_event,
  output logic                trap,
  output logic                mret,
  output logic [1:0]          mode,
  output logic [31:0]         mtvec,
  output logic [31:0]         mepc,
  output logic [63:0]         minstret,
  output logic [31:0]         mcounteren
);

  localparam logic [31:0] MIE_MASK = irq_mask(LIRQ_NUM);
`ifdef CSR_HPM_EN
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << HPM_NUM) - 32'h1) << 3);
`else
  localparam logic [31:0] INH_MASK = 32'h5;
`endif

  csr_state_t     st_q, st_d;
  logic [31:0]    mip_q, mip_d;
  logic           trap_q, mret_q;
  cnt64_t [1:0]   cnt;
  csr_machine_reg regs;
  logic [31:0]    pend;
  logic [4:0]     irq_cause;
  logic           trap_taken;

  always_comb begin
    mip_d = '0;
    mip_d[MIP_MEI] = meip;
    mip_d[MIP_MTI] = mtip;
    mip_d[MIP_MSI] = msip;
    mip_d[MIP_LOCAL +: LIRQ_NUM] = lirq;
  end

  assign pend       = mip_q & st_q.mie & {32{st_q.st_mie}};
  assign trap_taken = exception || (|pend && valid);

  // Walk lowest priority first so the highest pending source wins.
  always_comb begin
    irq_cause = '0;
    for (int unsigned i = LIRQ_NUM; i > 0; i--)
      if (pend[MIP_LOCAL + i - 1]) irq_cause = 5'(MIP_LOCAL + i - 1);
    if (pend[MIP_MTI]) irq_cause = IRQ_MTI;
    if (pend[MIP_MSI]) irq_cause = IRQ_MSI;
    if (pend[MIP_MEI]) irq_cause = IRQ_MEI;
  end

  // CSR write first, then mret, then trap, so later updates override earlier ones.
  always_comb begin
    st_d = st_q;
    if (cwren) begin
      case (cwaddr)
        CSR_MSTATUS: begin
          st_d.st_mie  = cwdata[MSTATUS_MIE];
          st_d.st_mpie = cwdata[MSTATUS_MPIE];
          if (cwdata[12:11] == MODE_M || cwdata[12:11] == MODE_U) st_d.st_mpp = cwdata[12:11];
        end
        CSR_MIE:           st_d.mie           = cwdata & MIE_MASK;
        CSR_MTVEC:         st_d.mtvec         = {cwdata[31:2], cwdata[1] ? 2'b00 : cwdata[1:0]};
        CSR_MCOUNTEREN:    st_d.mcounteren    = cwdata;
        CSR_MCOUNTINHIBIT: st_d.mcountinhibit = cwdata & INH_MASK;
        CSR_MSCRATCH:      st_d.mscratch      = cwdata;
        CSR_MEPC:          st_d.mepc          = cwdata;
        CSR_MCAUSE:        st_d.mcause        = cwdata;
        CSR_MTVAL:         st_d.mtval         = cwdata;
        default: ;
      endcase
    end
    if (trap_taken) begin
      st_d.mepc    = epc;
      st_d.mtval   = exception ? etval : '0;
      st_d.mcause  = exception ? {27'b0, ecause} : {1'b1, 26'b0, irq_cause};
      st_d.st_mpie = st_q.st_mie;
      st_d.st_mie  = 1'b0;
      st_d.st_mpp  = st_q.mode;
      st_d.mode    = MODE_M;
    end else if (mret_in) begin
      st_d.st_mie  = st_q.st_mpie;
      st_d.st_mpie = 1'b1;
      st_d.mode    = st_q.st_mpp;
      st_d.st_mpp  = MODE_U;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q      <= '0;
      st_q.mode <= MODE_M;
      mip_q     <= '0;
      trap_q    <= 1'b0;
      mret_q    <= 1'b0;
    end else begin
      st_q   <= st_d;
      mip_q  <= mip_d;
      trap_q <= trap_taken;
      mret_q <= mret_in && !trap_taken;
    end
  end

  csr_counter64 u_mcycle (
    .clock     (clock),
    .reset     (reset),
    .inhibit_i (st_q.mcountinhibit[0]),
    .inc_i     (1'b1),
    .wr_lo_i   (cwren && cwaddr == CSR_MCYCLE),
    .wr_hi_i   (cwren && cwaddr == CSR_MCYCLEH),
    .wdata_i   (cwdata),
    .count_o   (cnt[CNT_CYCLE])
  );

  csr_counter64 u_minstret (
    .clock     (clock),
    .reset     (reset),
    .inhibit_i (st_q.mcountinhibit[2]),
    .inc_i     (valid),
    .wr_lo_i   (cwren && cwaddr == CSR_MINSTRET),
    .wr_hi_i   (cwren && cwaddr == CSR_MINSTRETH),
    .wdata_i   (cwdata),
    .count_o   (cnt[CNT_INSTRET])
  );

`ifdef CSR_HPM_EN
  cnt64_t [HPM_NUM-1:0]      hpm_cnt;
  logic   [HPM_NUM-1:0][31:0] hpm_evt_q;

  for (genvar i = 0; i < HPM_NUM; i++) begin : g_hpm
    csr_counter64 u_hpm (
      .clock     (clock),
      .reset     (reset),
      .inhibit_i (st_q.mcountinhibit[3 + i]),
      .inc_i     (hpm_event[i]),
      .wr_lo_i   (cwren && cwaddr == CSR_MHPMCNT_BASE + 12'(i)),
      .wr_hi_i   (cwren && cwaddr == CSR_MHPMCNTH_BASE + 12'(i)),
      .wdata_i   (cwdata),
      .count_o   (hpm_cnt[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hpm_evt_q <= '0;
    end else if (cwren) begin
      for (int unsigned i = 0; i < HPM_NUM; i++)
        if (cwaddr == CSR_MHPMEVENT_BASE + 12'(i)) hpm_evt_q[i] <= cwdata;
    end
  end
`else
  logic unused_hpm_event;
  assign unused_hpm_event = ^hpm_event;
`endif

  always_comb begin
    regs.st  = st_q;
    regs.mip = mip_q;
    regs.cnt = cnt;
  end

  always_comb begin
    crdata = '0;
    if (crden) begin
      case (craddr)
        CSR_MSTATUS:       crdata = {19'b0, regs.st.st_mpp, 3'b0, regs.st.st_mpie, 3'b0, regs.st.st_mie, 3'b0};
        CSR_MISA:          crdata = MISA_VALUE;
        CSR_MIE:           crdata = regs.st.mie;
        CSR_MTVEC:         crdata = regs.st.mtvec;
        CSR_MCOUNTEREN:    crdata = regs.st.mcounteren;
        CSR_MCOUNTINHIBIT: crdata = regs.st.mcountinhibit;
        CSR_MSCRATCH:      crdata = regs.st.mscratch;
        CSR_MEPC:          crdata = regs.st.mepc;
        CSR_MCAUSE:        crdata = regs.st.mcause;
        CSR_MTVAL:         crdata = regs.st.mtval;
        CSR_MIP:           crdata = regs.mip;
        CSR_MCYCLE:        crdata = regs.cnt[CNT_CYCLE][31:0];
        CSR_MCYCLEH:       crdata = regs.cnt[CNT_CYCLE][63:32];
        CSR_MINSTRET:      crdata = regs.cnt[CNT_INSTRET][31:0];
        CSR_MINSTRETH:     crdata = regs.cnt[CNT_INSTRET][63:32];
        default: ;
      endcase
`ifdef CSR_HPM_EN
      for (int unsigned i = 0; i < HPM_NUM; i++) begin
        if (craddr == CSR_MHPMCNT_BASE + 12'(i))   crdata = hpm_cnt[i][31:0];
        if (craddr == CSR_MHPMCNTH_BASE + 12'(i))  crdata = hpm_cnt[i][63:32];
        if (craddr == CSR_MHPMEVENT_BASE + 12'(i)) crdata = hpm_evt_q[i];
      end
`endif
    end
  end

  // Vectored target adds the cause in 30-bit word-address space.
  always_comb begin
    if (regs.st.mtvec[1:0] == 2'b01 && regs.st.mcause[31])
      mtvec = {regs.st.mtvec[31:2] + {25'b0, regs.st.mcause[4:0]}, 2'b00};
    else
      mtvec = {regs.st.mtvec[31:2], 2'b00};
  end

  assign trap       = trap_q;
  assign mret       = mret_q;
  assign mode       = regs.st.mode;
  assign mepc       = regs.st.mepc;
  assign minstret   = regs.cnt[CNT_INSTRET];
  assign mcounteren = regs.st.mcounteren;

endmodule

// File: tb/tb_csr_machine.sv
// Directed self-checking bench for csr_machine; HPM checks follow CSR_HPM_EN.
module tb_csr_machine;

  logic        clock = 1'b0;
  logic        reset;
  logic        crden;
  logic [11:0] craddr;
  logic [31:0] crdata;
  logic        cwren;
  logic [11:0] cwaddr;
  logic [31:0] cwdata;
  logic        valid, exception, mret_in;
  logic [4:0]  ecause;
  logic [31:0] epc, etval;
  logic        meip, msip, mtip;
  logic [3:0]  lirq, hpm_event;
  logic        trap, mret;
  logic [1:0]  mode;
  logic [31:0] mtvec, mepc, mcounteren;
  logic [63:0] minstret;

  int total = 0;
  int bad   = 0;

  csr_machine #(.LIRQ_NUM(4), .HPM_NUM(4)) dut (
    .clock(clock), .reset(reset),
    .crden(crden), .craddr(craddr), .crdata(crdata),
    .cwren(cwren), .cwaddr(cwaddr), .cwdata(cwdata),
    .valid(valid), .exception(exception), .ecause(ecause), .epc(epc), .etval(etval),
    .mret_in(mret_in), .meip(meip), .msip(msip), .mtip(mtip),
    .lirq(lirq), .hpm_event(hpm_event),
    .trap(trap), .mret(mret), .mode(mode), .mtvec(mtvec), .mepc(mepc),
    .minstret(minstret), .mcounteren(mcounteren)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cwren = 1'b1; cwaddr = a; cwdata = d;
    tick();
    cwren = 1'b0;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    crden = 1'b1; craddr = a;
    #1;
    d = crdata;
    crden = 1'b0;
    check(tag, {32'b0, d}, {32'b0, exp});
  endtask

  initial begin
    reset = 1'b0; crden = 1'b0; craddr = '0; cwren = 1'b0; cwaddr = '0; cwdata = '0;
    valid = 1'b0; exception = 1'b0; ecause = '0; epc = '0; etval = '0; mret_in = 1'b0;
    meip = 1'b0; msip = 1'b0; mtip = 1'b0; lirq = '0; hpm_event = '0;
    repeat (3) tick();

    // reset state
    chk_csr("misa", 12'h301, 32'h4000_1104);
    chk_csr("mstatus_rst", 12'h300, 32'h0);
    chk_csr("mcycle_rst", 12'hB00, 32'h0);
    check("mode_rst", {62'b0, mode}, 64'h3);
    check("trap_rst", {63'b0, trap}, 64'h0);
    check("minstret_rst", minstret, 64'h0);
    craddr = 12'h301; #1;
    check("crden_off", {32'b0, crdata}, 64'h0);
    reset = 1'b1;

    // write legalisation
    wr(12'h305, 32'h203);
    chk_csr("mtvec_mode3", 12'h305, 32'h200);
    wr(12'h300, 32'h1000);
    chk_csr("mpp_illegal", 12'h300, 32'h0);
    chk_csr("unimpl", 12'h7C0, 32'h0);
    wr(12'h344, 32'hFFFF_FFFF);
    chk_csr("mip_ro", 12'h344, 32'h0);
    wr(12'h304, 32'hFFFF_FFFF);
    chk_csr("mie_mask", 12'h304, 32'h000F_0888);
    wr(12'h306, 32'h5);
    check("mcounteren", {32'b0, mcounteren}, 64'h5);

    // MEI + MSI together, only MEI enabled, vectored mtvec
    wr(12'h304, 32'h800);
    wr(12'h305, 32'h101);
    wr(12'h300, 32'h8);
    meip = 1'b1; msip = 1'b1; valid = 1'b1; epc = 32'h2000;
    tick();
    check("irq_trap_early", {63'b0, trap}, 64'h0);
    chk_csr("mip_sampled", 12'h344, 32'h808);
    tick();
    check("irq_trap", {63'b0, trap}, 64'h1);
    chk_csr("irq_mcause", 12'h342, 32'h8000_000B);
    check("irq_mtvec", {32'b0, mtvec}, 64'h12C);
    check("irq_mepc", {32'b0, mepc}, 64'h2000);
    chk_csr("irq_mstatus", 12'h300, 32'h1880);
    meip = 1'b0; msip = 1'b0; valid = 1'b0;
    tick();
    check("irq_pulse_end", {63'b0, trap}, 64'h0);

    // exception beats a pending, enabled MTI
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    mtip = 1'b1;
    tick();
    exception = 1'b1; ecause = 5'd2; epc = 32'h3000; etval = 32'h55; valid = 1'b1;
    tick();
    exception = 1'b0; valid = 1'b0; mtip = 1'b0;
    check("exc_trap", {63'b0, trap}, 64'h1);
    chk_csr("exc_mcause", 12'h342, 32'h2);
    check("exc_mepc", {32'b0, mepc}, 64'h3000);
    chk_csr("exc_mtval", 12'h343, 32'h55);
    check("exc_mtvec", {32'b0, mtvec}, 64'h100);

    // local interrupts: lirq[0] outranks lirq[1]
    wr(12'h304, 32'h3_0000);
    wr(12'h300, 32'h8);
    lirq = 4'b0011;
    tick();
    valid = 1'b1;
    tick();
    valid = 1'b0; lirq = '0;
    check("lirq_trap", {63'b0, trap}, 64'h1);
    chk_csr("lirq_mcause", 12'h342, 32'h8000_0010);
    check("lirq_mtvec", {32'b0, mtvec}, 64'h140);
    chk_csr("lirq_mtval", 12'h343, 32'h0);

    // mcycle wrap and write-beats-increment
    wr(12'hB00, 32'hFFFF_FFFF);
    chk_csr("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    chk_csr("mcycle_lo_hold", 12'hB00, 32'hFFFF_FFFF);
    chk_csr("mcycleh_wr", 12'hB80, 32'hFFFF_FFFF);
    tick();
    chk_csr("mcycle_wrap", 12'hB00, 32'h0);
    chk_csr("mcycleh_wrap", 12'hB80, 32'h0);

    // inhibit and minstret
    wr(12'h320, 32'hFFFF_FFFF);
`ifdef CSR_HPM_EN
    chk_csr("inhibit_mask", 12'h320, 32'h7D);
`else
    chk_csr("inhibit_mask", 12'h320, 32'h5);
`endif
    wr(12'h320, 32'h5);
    wr(12'hB00, 32'h100);
    wr(12'hB02, 32'h7);
    valid = 1'b1;
    repeat (2) tick();
    valid = 1'b0;
    chk_csr("mcycle_inhibit", 12'hB00, 32'h100);
    check("minstret_inhibit", minstret, 64'h7);
    wr(12'h320, 32'h0);
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    check("minstret_count", minstret, 64'd10);

    // mret round trip through U mode
    wr(12'h300, 32'h80);
    mret_in = 1'b1;
    tick();
    mret_in = 1'b0;
    check("mret1_pulse", {63'b0, mret}, 64'h1);
    check("mret1_mode", {62'b0, mode}, 64'h0);
    chk_csr("mret1_mstatus", 12'h300, 32'h88);
    exception = 1'b1; ecause = 5'd3; epc = 32'h4000; valid = 1'b1;
    tick();
    exception = 1'b0; valid = 1'b0;
    check("u_trap_mode", {62'b0, mode}, 64'h3);
    chk_csr("u_trap_mstatus", 12'h300, 32'h80);
    mret_in = 1'b1;
    tick();
    mret_in = 1'b0;
    check("mret2_pulse", {63'b0, mret}, 64'h1);
    check("mret2_mode", {62'b0, mode}, 64'h0);
    chk_csr("mret2_mstatus", 12'h300, 32'h88);
    tick();
    check("mret2_pulse_end", {63'b0, mret}, 64'h0);

    // trap beats mret and a same-cycle mepc write
    exception = 1'b1; ecause = 5'd4; epc = 32'h5000; mret_in = 1'b1;
    cwren = 1'b1; cwaddr = 12'h341; cwdata = 32'hDEAD;
    tick();
    exception = 1'b0; mret_in = 1'b0; cwren = 1'b0;
    check("prio_trap", {63'b0, trap}, 64'h1);
    check("prio_mret", {63'b0, mret}, 64'h0);
    check("prio_mepc", {32'b0, mepc}, 64'h5000);
    check("prio_mode", {62'b0, mode}, 64'h3);

    // HPM counters
    hpm_event = 4'b0010;
    repeat (5) tick();
    hpm_event = '0;
`ifdef CSR_HPM_EN
    wr(12'h320, 32'h10);
    hpm_event = 4'b0010;
    repeat (3) tick();
    hpm_event = '0;
    chk_csr("hpm4", 12'hB04, 32'h5);
    chk_csr("hpm4h", 12'hB84, 32'h0);
    wr(12'h324, 32'hABCD);
    chk_csr("hpmevent4", 12'h324, 32'hABCD);
`else
    chk_csr("hpm4_off", 12'hB04, 32'h0);
    wr(12'hB04, 32'h1234);
    chk_csr("hpm4_wr_off", 12'hB04, 32'h0);
`endif

    // reset wins over a same-cycle trap
    exception = 1'b1; epc = 32'h6000; valid = 1'b1; reset = 1'b0;
    tick();
    exception = 1'b0; valid = 1'b0;
    check("rst_trap", {63'b0, trap}, 64'h0);
    check("rst_mepc", {32'b0, mepc}, 64'h0);
    check("rst_mode", {62'b0, mode}, 64'h3);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
